vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_pkg.sv | 18 +
 rtl/fb_addr_calc.sv | 10 +
 rtl/vga_fb_arbiter.sv | 149 ++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, write-buffer state encoding and a range helper
// for the VGA framebuffer arbiter.
package vga_pkg;
  localparam int FB_COLS   = 160;
  localparam int FB_ROWS   = 120;
  localparam int FB_ADDR_W = 15;
  localparam int PIXEL_W   = 3;
  localparam int FB_X_W    = 8;
  localparam int FB_Y_W    = 7;

  localparam logic [0:0] WR_EMPTY = 1'b0;
  localparam logic [0:0] WR_FULL  = 1'b1;

  function automatic logic fb_in_range(input logic [FB_X_W-1:0] x,
                                       input logic [FB_Y_W-1:0] y);
    return (x < 8'(FB_COLS)) && (y < 7'(FB_ROWS));
  endfunction
endpackage

// File: rtl/fb_addr_calc.sv
// Framebuffer cell address Y*160 + X, built from shifts so no multiplier is needed.
module fb_addr_calc
  import vga_pkg::*;
(
  input  logic [FB_X_W-1:0]    x_i,
  input  logic [FB_Y_W-1:0]    y_i,
  output logic [FB_ADDR_W-1:0] addr_o
);
  assign addr_o = (FB_ADDR_W'(y_i) << 4'd7) + (FB_ADDR_W'(y_i) << 4'd5) + FB_ADDR_W'(x_i);
endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between raster readout (every 4th active
// column) and a one-entry host write buffer that drains in the free slots.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [9:0]           i_Col_Count,
  input  logic [9:0]           i_Row_Count,
  input  logic                 i_HSync,
  input  logic                 i_VSync,
  input  logic                 i_Wr_Valid,
  input  logic [FB_X_W-1:0]    i_Wr_X,
  input  logic [FB_Y_W-1:0]    i_Wr_Y,
  input  logic [PIXEL_W-1:0]   i_Wr_Data,
  output logic                 o_Wr_Ready,
  output logic                 o_Wr_Drop,
  output logic [FB_ADDR_W-1:0] o_Mem_Addr,
  output logic                 o_Mem_WE,
  output logic [PIXEL_W-1:0]   o_Mem_WData,
  input  logic [PIXEL_W-1:0]   i_Mem_RData,
  output logic [PIXEL_W-1:0]   o_Pixel,
  output logic                 o_Active,
  output logic                 o_HSync,
  output logic                 o_VSync
);
  localparam logic [9:0] ACT_COLS_C = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS_C = 10'(ACTIVE_ROWS);

  logic                 active_s, disp_slot_s;
  logic                 accept_s, in_range_s, grant_s;
  logic [FB_ADDR_W-1:0] disp_addr_s, wr_addr_s;

  logic [0:0]           state_q, state_d;
  logic [FB_X_W-1:0]    wr_x_q;
  logic [FB_Y_W-1:0]    wr_y_q;
  logic [PIXEL_W-1:0]   wr_data_q;
  logic                 ready_q, drop_q;
  logic                 slot_q;
  logic [PIXEL_W-1:0]   hold_q, pixel_q;
  logic                 active_p1_q, active_p2_q;
  logic                 hsync_p1_q, hsync_p2_q;
  logic                 vsync_p1_q, vsync_p2_q;

  fb_addr_calc u_disp_addr (
    .x_i    (i_Col_Count[9:2]),
    .y_i    (i_Row_Count[8:2]),
    .addr_o (disp_addr_s)
  );

  fb_addr_calc u_wr_addr (
    .x_i    (wr_x_q),
    .y_i    (wr_y_q),
    .addr_o (wr_addr_s)
  );

  assign active_s    = (i_Col_Count < ACT_COLS_C) && (i_Row_Count < ACT_ROWS_C);
  assign disp_slot_s = active_s && (i_Col_Count[1:0] == 2'b00);
  assign accept_s    = i_Wr_Valid && ready_q;
  assign in_range_s  = fb_in_range(i_Wr_X, i_Wr_Y);
  // Display reads always win the port; a buffered write just waits one cycle.
  assign grant_s     = (state_q == WR_FULL) && !disp_slot_s && !i_Rst;

  always_comb begin
    state_d = state_q;
    if (accept_s && in_range_s) begin
      state_d = WR_FULL;
    end else if (grant_s) begin
      state_d = WR_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    o_Mem_Addr  = '0;
    o_Mem_WE    = 1'b0;
    o_Mem_WData = '0;
    if (i_Rst) begin
      o_Mem_Addr = '0;
    end else if (grant_s) begin
      o_Mem_Addr  = wr_addr_s;
      o_Mem_WE    = 1'b1;
      o_Mem_WData = wr_data_q;
    end else if (disp_slot_s) begin
      o_Mem_Addr = disp_addr_s;
    end else begin
      o_Mem_Addr = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= WR_EMPTY;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_data_q   <= '0;
      ready_q     <= 1'b0;
      drop_q      <= 1'b0;
      slot_q      <= 1'b0;
      hold_q      <= '0;
      pixel_q     <= '0;
      active_p1_q <= 1'b0;
      active_p2_q <= 1'b0;
      hsync_p1_q  <= 1'b1;
      hsync_p2_q  <= 1'b1;
      vsync_p1_q  <= 1'b1;
      vsync_p2_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept_s && in_range_s) begin
        wr_x_q    <= i_Wr_X;
        wr_y_q    <= i_Wr_Y;
        wr_data_q <= i_Wr_Data;
      end
      ready_q <= (state_d == WR_EMPTY);
      drop_q  <= accept_s && !in_range_s;
      // RAM data for a display slot arrives one cycle later; pixel_q mirrors
      // the hold register so the pixel lands exactly two cycles after its count.
      slot_q  <= disp_slot_s;
      if (slot_q) begin
        hold_q <= i_Mem_RData;
      end
      if (!active_p1_q) begin
        pixel_q <= '0;
      end else if (slot_q) begin
        pixel_q <= i_Mem_RData;
      end else begin
        pixel_q <= hold_q;
      end
      active_p1_q <= active_s;
      active_p2_q <= active_p1_q;
      hsync_p1_q  <= i_HSync;
      hsync_p2_q  <= hsync_p1_q;
      vsync_p1_q  <= i_VSync;
      vsync_p2_q  <= vsync_p1_q;
    end
  end

  assign o_Wr_Ready = ready_q;
  assign o_Wr_Drop  = drop_q;
  assign o_Pixel    = pixel_q;
  assign o_Active   = active_p2_q;
  assign o_HSync    = hsync_p2_q;
  assign o_VSync    = vsync_p2_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: blanking write-path vector table, then
// hand-written raster sequences around display slots, a back-to-back line and reset.
module tb_vga_fb_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hs, vs, wv;
  logic [9:0]  col, row;
  logic [7:0]  wx;
  logic [6:0]  wy;
  logic [2:0]  wd;
  logic        o_Wr_Ready, o_Wr_Drop, o_Mem_WE, o_Active, o_HSync, o_VSync;
  logic [14:0] o_Mem_Addr;
  logic [2:0]  o_Mem_WData, o_Pixel, rdata;

  vga_fb_arbiter #(.ACTIVE_COLS(640), .ACTIVE_ROWS(480)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Col_Count(col), .i_Row_Count(row),
    .i_HSync(hs), .i_VSync(vs), .i_Wr_Valid(wv), .i_Wr_X(wx), .i_Wr_Y(wy),
    .i_Wr_Data(wd), .o_Wr_Ready(o_Wr_Ready), .o_Wr_Drop(o_Wr_Drop),
    .o_Mem_Addr(o_Mem_Addr), .o_Mem_WE(o_Mem_WE), .o_Mem_WData(o_Mem_WData),
    .i_Mem_RData(rdata), .o_Pixel(o_Pixel), .o_Active(o_Active),
    .o_HSync(o_HSync), .o_VSync(o_VSync)
  );

  // Framebuffer RAM model: read-first, one-cycle read latency.
  logic [2:0] ram [0:32767];
  always @(posedge clk) begin
    if (o_Mem_WE) ram[o_Mem_Addr] <= o_Mem_WData;
    rdata <= ram[o_Mem_Addr];
  end

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int viol = 0;
  int sb_bad = 0;
  logic sb_en = 1'b0;
  logic [17:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [9:0] c, input logic [9:0] rw,
                       input logic h, input logic v_s, input logic val,
                       input logic [7:0] x, input logic [6:0] y, input logic [2:0] d);
    @(posedge clk);
    #1;
    rst = r; col = c; row = rw; hs = h; vs = v_s; wv = val; wx = x; wy = y; wd = d;
    @(negedge clk);
  endtask

  // Port-usage monitor: no write in a display slot, no write while ready, scoreboard.
  always @(negedge clk) begin
    logic slot_b;
    logic [17:0] e;
    slot_b = !rst && (col < 10'd640) && (row < 10'd480) && (col[1:0] == 2'b00);
    if (o_Mem_WE === 1'b1) begin
      we_count++;
      if (slot_b || o_Wr_Ready) viol++;
      if (sb_en) begin
        if (exp_q.size() == 0) sb_bad++;
        else begin
          e = exp_q.pop_front();
          if (e !== {o_Mem_Addr, o_Mem_WData}) sb_bad++;
        end
      end
    end
  end

  typedef struct {
    logic hs, vs, v;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] d;
    logic e_rdy, e_drop, e_we;
    logic [14:0] e_addr;
    logic [2:0] e_wd;
    logic e_hs, e_vs;
  } vec_t;

  function automatic vec_t mk(input logic h, input logic v_s, input logic v,
                              input logic [7:0] x, input logic [6:0] y, input logic [2:0] d,
                              input logic rdy, input logic drop, input logic we,
                              input logic [14:0] addr, input logic [2:0] wdat,
                              input logic eh, input logic ev);
    vec_t t;
    t.hs = h; t.vs = v_s; t.v = v; t.x = x; t.y = y; t.d = d;
    t.e_rdy = rdy; t.e_drop = drop; t.e_we = we; t.e_addr = addr; t.e_wd = wdat;
    t.e_hs = eh; t.e_vs = ev;
    return t;
  endfunction

  vec_t tbl [14];
  logic [2:0] exp_pix [12] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                               3'd5, 3'd5, 3'd5, 3'd5, 3'd0, 3'd0};

  initial begin
    int k, pix_bad, we_before;
    logic exp_act;
    logic [2:0] exp_p;
    rst = 1'b1; col = 10'd700; row = 10'd10; hs = 1'b1; vs = 1'b1;
    wv = 1'b0; wx = 8'd0; wy = 7'd0; wd = 3'd0;
    for (int i = 0; i < 32768; i++) ram[i] = 3'd0;
    for (int i = 0; i < 160; i++) ram[800 + i] = 3'(i % 8);

    // Blanking write-path vectors (col 700, row 10), hs/vs delayed by two.
    tbl[0]  = mk(1, 1, 1, 8'd5,   7'd3,   3'd6, 1, 0, 0, 15'd0,     3'd0, 1, 1);
    tbl[1]  = mk(1, 1, 0, 8'd0,   7'd0,   3'd0, 0, 0, 1, 15'd485,   3'd6, 1, 1);
    tbl[2]  = mk(0, 1, 0, 8'd0,   7'd0,   3'd0, 1, 0, 0, 15'd0,     3'd0, 1, 1);
    tbl[3]  = mk(0, 1, 1, 8'd160, 7'd0,   3'd1, 1, 0, 0, 15'd0,     3'd0, 1, 1);
    tbl[4]  = mk(1, 1, 0, 8'd0,   7'd0,   3'd0, 1, 1, 0, 15'd0,     3'd0, 0, 1);
    tbl[5]  = mk(1, 0, 0, 8'd0,   7'd0,   3'd0, 1, 0, 0, 15'd0,     3'd0, 0, 1);
    tbl[6]  = mk(1, 1, 1, 8'd159, 7'd119, 3'd7, 1, 0, 0, 15'd0,     3'd0, 1, 1);
    tbl[7]  = mk(1, 1, 0, 8'd0,   7'd0,   3'd0, 0, 0, 1, 15'd19199, 3'd7, 1, 0);
    tbl[8]  = mk(1, 1, 1, 8'd0,   7'd120, 3'd2, 1, 0, 0, 15'd0,     3'd0, 1, 1);
    tbl[9]  = mk(1, 1, 0, 8'd0,   7'd0,   3'd0, 1, 1, 0, 15'd0,     3'd0, 1, 1);
    tbl[10] = mk(1, 1, 1, 8'd1,   7'd1,   3'd5, 1, 0, 0, 15'd0,     3'd0, 1, 1);
    tbl[11] = mk(1, 1, 1, 8'd2,   7'd2,   3'd3, 0, 0, 1, 15'd161,   3'd5, 1, 1);
    tbl[12] = mk(1, 1, 0, 8'd0,   7'd0,   3'd0, 1, 0, 0, 15'd0,     3'd0, 1, 1);
    tbl[13] = mk(1, 1, 0, 8'd0,   7'd0,   3'd0, 1, 0, 0, 15'd0,     3'd0, 1, 1);

    // Power-on reset with syncs driven low: outputs must hold reset values.
    for (int i = 0; i < 3; i++) apply(1, 10'd700, 10'd10, 0, 0, 1, 8'd1, 7'd1, 3'd1);
    chk("rst_ready", o_Wr_Ready, 0);
    chk("rst_hsync", o_HSync, 1);
    chk("rst_vsync", o_VSync, 1);
    chk("rst_we", o_Mem_WE, 0);
    chk("rst_pixel", o_Pixel, 0);
    apply(0, 10'd700, 10'd10, 1, 1, 0, 8'd0, 7'd0, 3'd0);
    chk("rel_ready_c1", o_Wr_Ready, 0);
    apply(0, 10'd700, 10'd10, 1, 1, 0, 8'd0, 7'd0, 3'd0);
    chk("rel_ready_c2", o_Wr_Ready, 1);
    apply(0, 10'd700, 10'd10, 1, 1, 0, 8'd0, 7'd0, 3'd0);

    for (int i = 0; i < 14; i++) begin
      apply(0, 10'd700, 10'd10, tbl[i].hs, tbl[i].vs, tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].d);
      chk($sformatf("t%0d_ready", i), o_Wr_Ready, tbl[i].e_rdy);
      chk($sformatf("t%0d_drop", i), o_Wr_Drop, tbl[i].e_drop);
      chk($sformatf("t%0d_we", i), o_Mem_WE, tbl[i].e_we);
      chk($sformatf("t%0d_addr", i), o_Mem_Addr, tbl[i].e_addr);
      chk($sformatf("t%0d_wdata", i), o_Mem_WData, tbl[i].e_wd);
      chk($sformatf("t%0d_hsync", i), o_HSync, tbl[i].e_hs);
      chk($sformatf("t%0d_vsync", i), o_VSync, tbl[i].e_vs);
      chk($sformatf("t%0d_active", i), o_Active, 0);
    end

    // Row 4: cell 161 (written above with 5) shows on cols 4..7, two cycles late.
    for (int c = 0; c < 12; c++) begin
      apply(0, 10'(c), 10'd4, 1, 1, 0, 8'd0, 7'd0, 3'd0);
      if (c == 0) chk("a_addr_c0", o_Mem_Addr, 160);
      if (c == 4) chk("a_addr_c4", o_Mem_Addr, 161);
      chk($sformatf("a_we_c%0d", c), o_Mem_WE, 0);
      if (c >= 2) begin
        chk($sformatf("a_pixel_c%0d", c), o_Pixel, exp_pix[c]);
        chk($sformatf("a_active_c%0d", c), o_Active, 1);
      end
    end

    // Buffer fills exactly on a display slot: write deferred by one cycle.
    apply(0, 10'd635, 10'd10, 1, 1, 1, 8'd10, 7'd10, 3'd4);
    chk("b_ready_635", o_Wr_Ready, 1);
    apply(0, 10'd636, 10'd10, 1, 1, 0, 8'd0, 7'd0, 3'd0);
    chk("b_we_636", o_Mem_WE, 0);
    chk("b_addr_636", o_Mem_Addr, 479);
    chk("b_ready_636", o_Wr_Ready, 0);
    apply(0, 10'd637, 10'd10, 1, 1, 0, 8'd0, 7'd0, 3'd0);
    chk("b_we_637", o_Mem_WE, 1);
    chk("b_addr_637", o_Mem_Addr, 1610);
    chk("b_wdata_637", o_Mem_WData, 4);
    apply(0, 10'd638, 10'd10, 1, 1, 0, 8'd0, 7'd0, 3'd0);
    chk("b_we_638", o_Mem_WE, 0);
    chk("b_ready_638", o_Wr_Ready, 1);
    apply(0, 10'd799, 10'd524, 1, 1, 1, 8'd7, 7'd0, 3'd2);
    apply(0, 10'd0, 10'd0, 1, 1, 0, 8'd0, 7'd0, 3'd0);
    chk("b_we_r0c0", o_Mem_WE, 0);
    chk("b_addr_r0c0", o_Mem_Addr, 0);
    apply(0, 10'd1, 10'd0, 1, 1, 0, 8'd0, 7'd0, 3'd0);
    chk("b_we_r0c1", o_Mem_WE, 1);
    chk("b_addr_r0c1", o_Mem_Addr, 7);
    apply(0, 10'd2, 10'd0, 1, 1, 0, 8'd0, 7'd0, 3'd0);
    chk("b_pixel_r0c2", o_Pixel, 0);
    chk("b_ready_r0c2", o_Wr_Ready, 1);

    // Full line (row 20 shows fb row 5) with the host always valid.
    k = 0; pix_bad = 0;
    #1;
    we_before = we_count;
    sb_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      apply(0, 10'(c), 10'd20, 1, 1, 1, 8'(k % 160), 7'd50, 3'((k % 7) + 1));
      if (o_Wr_Ready) begin
        exp_q.push_back({15'(50 * 160 + (k % 160)), 3'((k % 7) + 1)});
        k++;
      end
      if (c >= 2) begin
        exp_act = (c <= 641);
        exp_p = exp_act ? 3'(((c - 2) >> 2) % 8) : 3'd0;
        if (o_Pixel !== exp_p || o_Active !== exp_act) pix_bad++;
      end
    end
    for (int i = 0; i < 4; i++) apply(0, 10'd700, 10'd21, 1, 1, 0, 8'd0, 7'd0, 3'd0);
    #1;
    sb_en = 1'b0;
    chk("c_we_count", we_count - we_before, k);
    chk("c_queue_empty", exp_q.size(), 0);
    chk("c_scoreboard", sb_bad, 0);
    chk("c_line_pixels", pix_bad, 0);
    chk("c_accepts_ge_280", (k >= 280), 1);

    // Reset mid-frame while the buffer is full: the write must vanish.
    apply(0, 10'd100, 10'd30, 1, 1, 1, 8'd3, 7'd3, 3'd1);
    chk("d_ready_accept", o_Wr_Ready, 1);
    #1;
    we_before = we_count;
    apply(1, 10'd101, 10'd30, 0, 0, 0, 8'd0, 7'd0, 3'd0);
    chk("d_we_rst1", o_Mem_WE, 0);
    chk("d_wdata_rst1", o_Mem_WData, 0);
    apply(1, 10'd102, 10'd30, 0, 0, 0, 8'd0, 7'd0, 3'd0);
    apply(1, 10'd104, 10'd30, 0, 0, 0, 8'd0, 7'd0, 3'd0);
    chk("d_addr_rst3", o_Mem_Addr, 0);
    chk("d_ready_rst3", o_Wr_Ready, 0);
    chk("d_drop_rst3", o_Wr_Drop, 0);
    chk("d_pixel_rst3", o_Pixel, 0);
    chk("d_active_rst3", o_Active, 0);
    chk("d_hsync_rst3", o_HSync, 1);
    chk("d_vsync_rst3", o_VSync, 1);
    apply(0, 10'd700, 10'd30, 1, 1, 0, 8'd0, 7'd0, 3'd0);
    chk("d_ready_r1", o_Wr_Ready, 0);
    apply(0, 10'd700, 10'd30, 1, 1, 0, 8'd0, 7'd0, 3'd0);
    chk("d_ready_r2", o_Wr_Ready, 1);
    apply(0, 10'd700, 10'd30, 1, 1, 0, 8'd0, 7'd0, 3'd0);
    #1;
    chk("d_no_we", we_count - we_before, 0);
    chk("port_conflicts", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
